// File: rtl/triangle_assembler.sv
// Triangle assembler: pops vertices from a non-FWFT FIFO, groups them in threes,
// clamps to the screen, computes doubled area and bbox, culls, and hands off to the rasterizer.
module triangle_assembler #(
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter bit CULL_BACKFACE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  input  logic [31:0] i_vx,
  input  logic [31:0] i_vy,
  input  logic [7:0]  i_vz,
  input  logic [31:0] i_vu,
  input  logic [31:0] i_vv,
  input  logic        i_frame_start,
  output logic        o_tri_valid,
  input  logic        i_tri_ready,
  output logic [8:0]  o_x0,
  output logic [8:0]  o_x1,
  output logic [8:0]  o_x2,
  output logic [8:0]  o_y0,
  output logic [8:0]  o_y1,
  output logic [8:0]  o_y2,
  output logic [7:0]  o_z0,
  output logic [7:0]  o_z1,
  output logic [7:0]  o_z2,
  output logic [31:0] o_u0,
  output logic [31:0] o_u1,
  output logic [31:0] o_u2,
  output logic [31:0] o_v0,
  output logic [31:0] o_v1,
  output logic [31:0] o_v2,
  output logic [19:0] o_area2,
  output logic [8:0]  o_bb_xmin,
  output logic [8:0]  o_bb_xmax,
  output logic [8:0]  o_bb_ymin,
  output logic [8:0]  o_bb_ymax,
  output logic [15:0] o_tri_count,
  output logic [15:0] o_cull_count,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a triangle transfers on any cycle where o_tri_valid && i_tri_ready;
  // once raised, o_tri_valid and all triangle outputs hold until that cycle.
  typedef enum logic [2:0] {
    S_FETCH, S_CAPTURE, S_SETUP, S_AREA, S_DECIDE, S_OUTPUT
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          vcount_q, vcount_d;
  logic [15:0]         vx_q [3], vx_d [3];
  logic [15:0]         vy_q [3], vy_d [3];
  logic [7:0]          vz_q [3], vz_d [3];
  logic [31:0]         vu_q [3], vu_d [3];
  logic [31:0]         vv_q [3], vv_d [3];
  logic [8:0]          cx_q [3], cx_d [3];
  logic [8:0]          cy_q [3], cy_d [3];
  logic [8:0]          cx_c [3], cy_c [3];
  logic signed [9:0]   dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dx2_d, dy2_q, dy2_d;
  logic signed [19:0]  area_q, area_d;
  logic [8:0]          xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [8:0]          ox_q [3], ox_d [3];
  logic [8:0]          oy_q [3], oy_d [3];
  logic [7:0]          oz_q [3], oz_d [3];
  logic [31:0]         ou_q [3], ou_d [3];
  logic [31:0]         ov_q [3], ov_d [3];
  logic signed [19:0]  oarea_q, oarea_d;
  logic [8:0]          obb_xmin_q, obb_xmin_d, obb_xmax_q, obb_xmax_d;
  logic [8:0]          obb_ymin_q, obb_ymin_d, obb_ymax_q, obb_ymax_d;
  logic                valid_q, valid_d;
  logic [15:0]         tri_cnt_q, tri_cnt_d, cull_cnt_q, cull_cnt_d;
  logic                unused_frac;

  // Only the integer part of Q16.16 matters for pixel coordinates.
  assign unused_frac = ^{i_vx[15:0], i_vy[15:0]};

  function automatic logic [8:0] clamp(input logic [15:0] c, input int lim);
    if ($signed(c) < 16'sd0)            return '0;
    else if (int'($signed(c)) > lim - 1) return 9'(lim - 1);
    else                                return c[8:0];
  endfunction

  function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    logic [8:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
    logic [8:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign o_fifo_rd_en = (state_q == S_FETCH) && !i_fifo_empty && !i_rst;

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      cx_c[j] = clamp(vx_q[j], SCREEN_W);
      cy_c[j] = clamp(vy_q[j], SCREEN_H);
    end
  end

  always_comb begin
    state_d    = state_q;
    vcount_d   = vcount_q;
    vx_d = vx_q;  vy_d = vy_q;  vz_d = vz_q;  vu_d = vu_q;  vv_d = vv_q;
    cx_d = cx_q;  cy_d = cy_q;
    dx1_d = dx1_q;  dy1_d = dy1_q;  dx2_d = dx2_q;  dy2_d = dy2_q;
    area_d = area_q;
    xmin_d = xmin_q;  xmax_d = xmax_q;  ymin_d = ymin_q;  ymax_d = ymax_q;
    ox_d = ox_q;  oy_d = oy_q;  oz_d = oz_q;  ou_d = ou_q;  ov_d = ov_q;
    oarea_d    = oarea_q;
    obb_xmin_d = obb_xmin_q;  obb_xmax_d = obb_xmax_q;
    obb_ymin_d = obb_ymin_q;  obb_ymax_d = obb_ymax_q;
    valid_d    = valid_q;
    tri_cnt_d  = tri_cnt_q;
    cull_cnt_d = cull_cnt_q;

    unique case (state_q)
      S_FETCH: begin
        if (i_frame_start)     vcount_d = '0;
        else if (o_fifo_rd_en) state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (i_frame_start) begin
          vcount_d = '0;
          state_d  = S_FETCH;
        end else begin
          vx_d[vcount_q] = i_vx[31:16];
          vy_d[vcount_q] = i_vy[31:16];
          vz_d[vcount_q] = i_vz;
          vu_d[vcount_q] = i_vu;
          vv_d[vcount_q] = i_vv;
          if (vcount_q == 2'd2) begin
            vcount_d = '0;
            state_d  = S_SETUP;
          end else begin
            vcount_d = vcount_q + 2'd1;
            state_d  = S_FETCH;
          end
        end
      end
      S_SETUP: begin
        cx_d  = cx_c;
        cy_d  = cy_c;
        dx1_d = $signed(10'(cx_c[1]) - 10'(cx_c[0]));
        dy1_d = $signed(10'(cy_c[1]) - 10'(cy_c[0]));
        dx2_d = $signed(10'(cx_c[2]) - 10'(cx_c[0]));
        dy2_d = $signed(10'(cy_c[2]) - 10'(cy_c[0]));
        state_d = S_AREA;
      end
      S_AREA: begin
        area_d  = 20'(dx1_q) * 20'(dy2_q) - 20'(dx2_q) * 20'(dy1_q);
        xmin_d  = min3(cx_q[0], cx_q[1], cx_q[2]);
        xmax_d  = max3(cx_q[0], cx_q[1], cx_q[2]);
        ymin_d  = min3(cy_q[0], cy_q[1], cy_q[2]);
        ymax_d  = max3(cy_q[0], cy_q[1], cy_q[2]);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (area_q == 20'sd0 || (area_q < 20'sd0 && CULL_BACKFACE)) begin
          cull_cnt_d = cull_cnt_q + 16'd1;
          state_d    = S_FETCH;
        end else begin
          ox_d = cx_q;  oy_d = cy_q;  oz_d = vz_q;  ou_d = vu_q;  ov_d = vv_q;
          oarea_d = area_q;
          // Clockwise winding is flipped to counter-clockwise so area stays positive.
          if (area_q < 20'sd0) begin
            ox_d[1] = cx_q[2];  ox_d[2] = cx_q[1];
            oy_d[1] = cy_q[2];  oy_d[2] = cy_q[1];
            oz_d[1] = vz_q[2];  oz_d[2] = vz_q[1];
            ou_d[1] = vu_q[2];  ou_d[2] = vu_q[1];
            ov_d[1] = vv_q[2];  ov_d[2] = vv_q[1];
            oarea_d = -area_q;
          end
          obb_xmin_d = xmin_q;  obb_xmax_d = xmax_q;
          obb_ymin_d = ymin_q;  obb_ymax_d = ymax_q;
          valid_d    = 1'b1;
          state_d    = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (i_tri_ready) begin
          valid_d   = 1'b0;
          tri_cnt_d = tri_cnt_q + 16'd1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_FETCH;
      vcount_q <= '0;
      vx_q <= '{default: '0};  vy_q <= '{default: '0};  vz_q <= '{default: '0};
      vu_q <= '{default: '0};  vv_q <= '{default: '0};
      cx_q <= '{default: '0};  cy_q <= '{default: '0};
      dx1_q <= '0;  dy1_q <= '0;  dx2_q <= '0;  dy2_q <= '0;
      area_q <= '0;
      xmin_q <= '0;  xmax_q <= '0;  ymin_q <= '0;  ymax_q <= '0;
      ox_q <= '{default: '0};  oy_q <= '{default: '0};  oz_q <= '{default: '0};
      ou_q <= '{default: '0};  ov_q <= '{default: '0};
      oarea_q    <= '0;
      obb_xmin_q <= '0;  obb_xmax_q <= '0;  obb_ymin_q <= '0;  obb_ymax_q <= '0;
      valid_q    <= 1'b0;
      tri_cnt_q  <= '0;
      cull_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      vcount_q <= vcount_d;
      vx_q <= vx_d;  vy_q <= vy_d;  vz_q <= vz_d;  vu_q <= vu_d;  vv_q <= vv_d;
      cx_q <= cx_d;  cy_q <= cy_d;
      dx1_q <= dx1_d;  dy1_q <= dy1_d;  dx2_q <= dx2_d;  dy2_q <= dy2_d;
      area_q <= area_d;
      xmin_q <= xmin_d;  xmax_q <= xmax_d;  ymin_q <= ymin_d;  ymax_q <= ymax_d;
      ox_q <= ox_d;  oy_q <= oy_d;  oz_q <= oz_d;  ou_q <= ou_d;  ov_q <= ov_d;
      oarea_q    <= oarea_d;
      obb_xmin_q <= obb_xmin_d;  obb_xmax_q <= obb_xmax_d;
      obb_ymin_q <= obb_ymin_d;  obb_ymax_q <= obb_ymax_d;
      valid_q    <= valid_d;
      tri_cnt_q  <= tri_cnt_d;
      cull_cnt_q <= cull_cnt_d;
    end
  end

  assign o_tri_valid  = valid_q;
  assign o_x0 = ox_q[0];  assign o_x1 = ox_q[1];  assign o_x2 = ox_q[2];
  assign o_y0 = oy_q[0];  assign o_y1 = oy_q[1];  assign o_y2 = oy_q[2];
  assign o_z0 = oz_q[0];  assign o_z1 = oz_q[1];  assign o_z2 = oz_q[2];
  assign o_u0 = ou_q[0];  assign o_u1 = ou_q[1];  assign o_u2 = ou_q[2];
  assign o_v0 = ov_q[0];  assign o_v1 = ov_q[1];  assign o_v2 = ov_q[2];
  assign o_area2      = oarea_q;
  assign o_bb_xmin    = obb_xmin_q;
  assign o_bb_xmax    = obb_xmax_q;
  assign o_bb_ymin    = obb_ymin_q;
  assign o_bb_ymax    = obb_ymax_q;
  assign o_tri_count  = tri_cnt_q;
  assign o_cull_count = cull_cnt_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Directed bench for triangle_assembler: instance 0 culls back faces, instance 1 flips them.
module tb_triangle_assembler;

  typedef struct {
    logic [31:0] x, y;
    logic [7:0]  z;
    logic [31:0] u, v;
  } vtx_t;

  logic        clk, rst, frame_start;
  logic        fifo_empty [2], rd [2], ready [2], valid [2];
  logic [31:0] vx [2], vy [2], vu [2], vv [2];
  logic [7:0]  vz [2];
  logic [8:0]  ox [2][3], oy [2][3];
  logic [7:0]  oz [2][3];
  logic [31:0] ou [2][3], ov [2][3];
  logic [19:0] area [2];
  logic [8:0]  bxmin [2], bxmax [2], bymin [2], bymax [2];
  logic [15:0] tcnt [2], ccnt [2];
  logic [2:0]  dbg [2];

  vtx_t fq0[$], fq1[$];
  int   errors = 0, checks = 0;
  logic last_rd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    triangle_assembler #(.SCREEN_W(320), .SCREEN_H(240), .CULL_BACKFACE(k == 0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_fifo_empty(fifo_empty[k]), .o_fifo_rd_en(rd[k]),
      .i_vx(vx[k]), .i_vy(vy[k]), .i_vz(vz[k]), .i_vu(vu[k]), .i_vv(vv[k]),
      .i_frame_start(frame_start), .o_tri_valid(valid[k]), .i_tri_ready(ready[k]),
      .o_x0(ox[k][0]), .o_x1(ox[k][1]), .o_x2(ox[k][2]),
      .o_y0(oy[k][0]), .o_y1(oy[k][1]), .o_y2(oy[k][2]),
      .o_z0(oz[k][0]), .o_z1(oz[k][1]), .o_z2(oz[k][2]),
      .o_u0(ou[k][0]), .o_u1(ou[k][1]), .o_u2(ou[k][2]),
      .o_v0(ov[k][0]), .o_v1(ov[k][1]), .o_v2(ov[k][2]),
      .o_area2(area[k]),
      .o_bb_xmin(bxmin[k]), .o_bb_xmax(bxmax[k]), .o_bb_ymin(bymin[k]), .o_bb_ymax(bymax[k]),
      .o_tri_count(tcnt[k]), .o_cull_count(ccnt[k]), .o_dbg_state(dbg[k])
    );
  end

  function automatic vtx_t mk(input int xi, input int yi, input int z);
    vtx_t t;
    t.x = 32'(xi) << 16;
    t.y = 32'(yi) << 16;
    t.z = 8'(z);
    t.u = 32'(1000 + z);
    t.v = 32'(2000 + z);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input vtx_t t);
    if (k == 0) fq0.push_back(t);
    else        fq1.push_back(t);
    fifo_empty[0] = (fq0.size() == 0);
    fifo_empty[1] = (fq1.size() == 0);
  endtask

  // Non-FWFT FIFO model: a pop seen at the edge presents data just after that edge.
  task automatic tick();
    logic p0, p1;
    vtx_t t;
    @(negedge clk);
    p0 = rd[0];
    p1 = rd[1];
    last_rd0 = p0;
    @(posedge clk);
    #1;
    if (p0 === 1'b1 && fq0.size() > 0) begin
      t = fq0.pop_front();
      vx[0] = t.x;  vy[0] = t.y;  vz[0] = t.z;  vu[0] = t.u;  vv[0] = t.v;
    end
    if (p1 === 1'b1 && fq1.size() > 0) begin
      t = fq1.pop_front();
      vx[1] = t.x;  vy[1] = t.y;  vz[1] = t.z;  vu[1] = t.u;  vv[1] = t.v;
    end
    fifo_empty[0] = (fq0.size() == 0);
    fifo_empty[1] = (fq1.size() == 0);
  endtask

  task automatic wait_valid(input int k, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid[k] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_tri(input int k, input vtx_t a, input vtx_t b, input vtx_t c);
    push(k, a);
    push(k, b);
    push(k, c);
  endtask

  vtx_t a0, a1, a2, b0, b1, b2;
  logic seen;
  int   bad;

  initial begin
    rst = 1'b1;  frame_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fifo_empty[k] = 1'b1;  ready[k] = 1'b1;
      vx[k] = '0;  vy[k] = '0;  vz[k] = '0;  vu[k] = '0;  vv[k] = '0;
    end
    a0 = mk(10, 10, 1);   a1 = mk(50, 10, 2);   a2 = mk(10, 40, 3);
    b0 = mk(100, 100, 4); b1 = mk(200, 120, 5); b2 = mk(150, 200, 6);
    tick();
    tick();
    rst = 1'b0;

    chk("reset_valid", 32'(valid[0]), 0);
    chk("reset_tri_count", 32'(tcnt[0]), 0);
    chk("reset_cull_count", 32'(ccnt[0]), 0);
    chk("reset_area", 32'(area[0]), 0);
    chk("reset_state", 32'(dbg[0]), 0);
    chk("reset_rd_en", 32'(rd[0]), 0);

    // Front-facing triangle with exact latency
    push_tri(0, a0, a1, a2);
    repeat (8) tick();
    chk("s1_not_early", 32'(valid[0]), 0);
    tick();
    chk("s1_valid_latency", 32'(valid[0]), 1);
    chk("s1_area", 32'(area[0]), 1200);
    chk("s1_x1", 32'(ox[0][1]), 50);
    chk("s1_y2", 32'(oy[0][2]), 40);
    chk("s1_z2", 32'(oz[0][2]), 3);
    chk("s1_u1", ou[0][1], 1002);
    chk("s1_bb_xmin", 32'(bxmin[0]), 10);
    chk("s1_bb_xmax", 32'(bxmax[0]), 50);
    chk("s1_bb_ymin", 32'(bymin[0]), 10);
    chk("s1_bb_ymax", 32'(bymax[0]), 40);
    chk("s1_count_before_hs", 32'(tcnt[0]), 0);
    tick();
    chk("s1_valid_drops", 32'(valid[0]), 0);
    chk("s1_tri_count", 32'(tcnt[0]), 1);

    // Back face: culled by instance 0, flipped by instance 1
    push_tri(0, a0, a2, a1);
    wait_valid(0, 14, seen);
    chk("s2_no_valid", 32'(seen), 0);
    chk("s2_cull_count", 32'(ccnt[0]), 1);
    chk("s2_tri_count_same", 32'(tcnt[0]), 1);
    push_tri(1, a0, a2, a1);
    wait_valid(1, 12, seen);
    chk("s2n_valid", 32'(seen), 1);
    chk("s2n_area", 32'(area[1]), 1200);
    chk("s2n_x1", 32'(ox[1][1]), 50);
    chk("s2n_y1", 32'(oy[1][1]), 10);
    chk("s2n_x2", 32'(ox[1][2]), 10);
    chk("s2n_y2", 32'(oy[1][2]), 40);
    chk("s2n_z1", 32'(oz[1][1]), 2);
    chk("s2n_v2", ov[1][2], 2003);
    chk("s2n_cull_count", 32'(ccnt[1]), 0);

    // Collinear triangle is culled
    push_tri(0, mk(0, 0, 7), mk(5, 5, 8), mk(10, 10, 9));
    wait_valid(0, 14, seen);
    chk("s3_collinear_no_valid", 32'(seen), 0);
    chk("s3_cull_count", 32'(ccnt[0]), 2);

    // Clamping: (-8,0)->(0,0), (400,300)->(319,239)
    push_tri(0, mk(-8, 0, 10), mk(400, 300, 11), mk(0, 100, 12));
    wait_valid(0, 12, seen);
    chk("s3_clamp_valid", 32'(seen), 1);
    chk("s3_x0_low", 32'(ox[0][0]), 0);
    chk("s3_x1_high", 32'(ox[0][1]), 319);
    chk("s3_y1_high", 32'(oy[0][1]), 239);
    chk("s3_area", 32'(area[0]), 31900);
    chk("s3_bb_xmax", 32'(bxmax[0]), 319);
    chk("s3_bb_ymax", 32'(bymax[0]), 239);
    tick();
    chk("s3_tri_count", 32'(tcnt[0]), 2);

    // Backpressure with six vertices queued
    ready[0] = 1'b0;
    push_tri(0, a0, a1, a2);
    push_tri(0, b0, b1, b2);
    wait_valid(0, 12, seen);
    chk("s4_valid", 32'(seen), 1);
    chk("s4_area_first", 32'(area[0]), 1200);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_rd0 !== 1'b0) bad++;
      if (valid[0] !== 1'b1 || ox[0][1] !== 9'd50 || area[0] !== 20'd1200) bad++;
    end
    chk("s4_stall_stable", 32'(bad), 0);
    chk("s4_no_pops", 32'(fq0.size()), 3);
    ready[0] = 1'b1;
    tick();
    chk("s4_hs_valid_drops", 32'(valid[0]), 0);
    chk("s4_tri_count_a", 32'(tcnt[0]), 3);
    wait_valid(0, 12, seen);
    chk("s4_second_valid", 32'(seen), 1);
    chk("s4_area_second", 32'(area[0]), 9000);
    chk("s4_bb_xmin", 32'(bxmin[0]), 100);
    chk("s4_bb_xmax", 32'(bxmax[0]), 200);
    chk("s4_bb_ymax", 32'(bymax[0]), 200);
    tick();
    chk("s4_tri_count_b", 32'(tcnt[0]), 4);

    // Frame flush discards two stale vertices
    push(0, mk(1, 1, 20));
    push(0, mk(2, 5, 21));
    repeat (6) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    push_tri(0, a0, a1, a2);
    wait_valid(0, 12, seen);
    chk("s5_valid", 32'(seen), 1);
    chk("s5_x0", 32'(ox[0][0]), 10);
    chk("s5_x1", 32'(ox[0][1]), 50);
    chk("s5_y2", 32'(oy[0][2]), 40);
    chk("s5_area", 32'(area[0]), 1200);
    chk("s5_cull_unchanged", 32'(ccnt[0]), 2);
    tick();
    wait_valid(0, 12, seen);
    chk("s5_single_triangle", 32'(seen), 0);
    chk("s5_tri_count", 32'(tcnt[0]), 5);

    // Reset while a triangle is pending
    ready[0] = 1'b0;
    push_tri(0, a0, a1, a2);
    wait_valid(0, 12, seen);
    chk("s6_valid_before_rst", 32'(seen), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_valid_cleared", 32'(valid[0]), 0);
    chk("s6_tri_count_cleared", 32'(tcnt[0]), 0);
    chk("s6_cull_count_cleared", 32'(ccnt[0]), 0);
    chk("s6_area_cleared", 32'(area[0]), 0);
    chk("s6_x1_cleared", 32'(ox[0][1]), 0);
    ready[0] = 1'b1;
    push_tri(0, b0, b1, b2);
    wait_valid(0, 12, seen);
    chk("s6_fresh_valid", 32'(seen), 1);
    chk("s6_fresh_area", 32'(area[0]), 9000);
    chk("s6_fresh_x1", 32'(ox[0][1]), 200);
    chk("s6_fresh_z2", 32'(oz[0][2]), 6);
    tick();
    chk("s6_tri_count", 32'(tcnt[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
